// File: rtl/fclk_div.sv
// fclk_div: programmable clock divider with clean start/stop and live ratio change.
// Define FCLK_DIV_SAFE_SWITCH_EN to defer ratio changes to the end of a period.
`timescale 1ns/1ps
module fclk_div #(
    parameter int unsigned          DIV_WIDTH = 4,
    parameter logic [DIV_WIDTH-1:0] INIT_DIV  = '0
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 EN,
    input  logic [DIV_WIDTH-1:0] DIV,
    input  logic                 LOAD,
    output logic                 O,
    output logic                 ACTIVE,
    output logic                 BUSY,
    output logic                 ACK
);

    localparam int unsigned NW = DIV_WIDTH + 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN
    } state_t;

    state_t                 state_q, state_d;
    logic [DIV_WIDTH-1:0]   cnt_q, cnt_d;
    logic                   o_q, o_d;
    logic                   active_q, active_d;
    logic                   busy_q, busy_d;
    logic                   ack_q, ack_d;
    logic [DIV_WIDTH-1:0]   cur_q, cur_d;
    logic [DIV_WIDTH-1:0]   pend_q, pend_d;

    logic [NW-1:0]          n_cur;
    logic [NW-1:0]          nm1_cur;
    logic [NW-1:0]          h_cur;
    logic                   wrap;
    logic [DIV_WIDTH-1:0]   cnt_inc;
    logic                   hi_next;
    logic                   apply_ok;
    logic                   apply;

    // Period length, high-phase length and counter step for the current ratio.
    always_comb begin
        n_cur = {1'b0, cur_q} + NW'(1);
        if (cur_q <= DIV_WIDTH'(1)) begin
            n_cur = NW'(2);
        end
        nm1_cur = n_cur - NW'(1);
        h_cur   = (n_cur + NW'(1)) >> 1;
        wrap    = ({1'b0, cnt_q} == nm1_cur);
        cnt_inc = wrap ? '0 : cnt_q + DIV_WIDTH'(1);
        hi_next = ({1'b0, cnt_inc} < h_cur);
    end

    // Decide when a pending ratio may become current.
    always_comb begin
`ifdef FCLK_DIV_SAFE_SWITCH_EN
        apply_ok = (state_q == ST_IDLE) || wrap;
`else
        apply_ok = 1'b1;
`endif
        // A fresh LOAD defers the switch so only the last code is applied.
        apply = busy_q && !LOAD && apply_ok;
    end

    // Next-state logic for run control, output phase and ratio bookkeeping.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        o_d     = o_q;
        cur_d   = cur_q;
        pend_d  = pend_q;
        busy_d  = busy_q;
        ack_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                o_d   = 1'b0;
                if (EN) begin
                    state_d = ST_RUN;
                    o_d     = 1'b1;
                end
            end
            ST_RUN: begin
                cnt_d = cnt_inc;
                o_d   = hi_next;
                if (!EN) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (EN) begin
                    state_d = ST_RUN;
                    cnt_d   = cnt_inc;
                    o_d     = hi_next;
                end else if (wrap) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    o_d     = 1'b0;
                end else begin
                    cnt_d = cnt_inc;
                    o_d   = hi_next;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
                o_d     = 1'b0;
            end
        endcase

        if (apply) begin
            cur_d  = pend_q;
            busy_d = 1'b0;
            ack_d  = 1'b1;
            // A running output restarts its period at the new ratio.
            if (state_q != ST_IDLE) begin
                cnt_d = '0;
                o_d   = (state_d != ST_IDLE);
            end
        end

        if (LOAD) begin
            pend_d = DIV;
            busy_d = 1'b1;
        end

        active_d = (state_d != ST_IDLE);
    end

    // All state and registered outputs; reset wins over every other input.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            o_q      <= 1'b0;
            active_q <= 1'b0;
            busy_q   <= 1'b0;
            ack_q    <= 1'b0;
            cur_q    <= INIT_DIV;
            pend_q   <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            o_q      <= o_d;
            active_q <= active_d;
            busy_q   <= busy_d;
            ack_q    <= ack_d;
            cur_q    <= cur_d;
            pend_q   <= pend_d;
        end
    end

    assign O      = o_q;
    assign ACTIVE = active_q;
    assign BUSY   = busy_q;
    assign ACK    = ack_q;

endmodule

// File: tb/tb_fclk_div.sv
// tb_fclk_div: directed scenarios plus randomized run against a period-level model.
// Expectations follow FCLK_DIV_SAFE_SWITCH_EN when it is defined for the build.
`timescale 1ns/1ps
module tb_fclk_div;

    localparam int W = 4;
`ifdef FCLK_DIV_SAFE_SWITCH_EN
    localparam bit SAFE = 1'b1;
`else
    localparam bit SAFE = 1'b0;
`endif

    logic         CLK = 1'b0;
    logic         RST;
    logic         EN;
    logic [W-1:0] DIV;
    logic         LOAD;
    logic         O;
    logic         ACTIVE;
    logic         BUSY;
    logic         ACK;

    int n_chk  = 0;
    int n_pass = 0;

    // reference model state
    int m_code, m_pend, m_pos;
    bit m_busy, m_on, m_stop, m_ack;

    fclk_div #(.DIV_WIDTH(W)) dut (
        .CLK    (CLK),
        .RST    (RST),
        .EN     (EN),
        .DIV    (DIV),
        .LOAD   (LOAD),
        .O      (O),
        .ACTIVE (ACTIVE),
        .BUSY   (BUSY),
        .ACK    (ACK)
    );

    always #5 CLK = ~CLK;

    initial begin
        #400000;
        $display("FAIL watchdog: run did not finish, checks %0d/%0d", n_pass, n_chk);
        $fatal(1);
    end

    task automatic cyc;
        @(posedge CLK);
        #1;
    endtask

    function automatic int ratio(input int code);
        int r;
        r = code + 1;
        if (r < 2) r = 2;
        return r;
    endfunction

    function automatic int hi_len(input int n);
        return (n + 1) / 2;
    endfunction

    task automatic go_idle(input string tag);
        int k;
        EN = 1'b0;
        k = 0;
        while (ACTIVE !== 1'b0 && k < 40) begin
            cyc;
            k++;
        end
        n_chk++;
        if (ACTIVE !== 1'b0 || O !== 1'b0) begin
            $display("FAIL %s_stop: ACTIVE=%b O=%b after %0d cyc, want 0 0",
                     tag, ACTIVE, O, k);
        end else begin
            n_pass++;
        end
    endtask

    task automatic load_idle(input int code, input string tag);
        LOAD = 1'b1;
        DIV  = W'(code);
        cyc;
        LOAD = 1'b0;
        n_chk++;
        if (BUSY !== 1'b1 || ACK !== 1'b0) begin
            $display("FAIL %s_load: BUSY=%b ACK=%b, want 1 0", tag, BUSY, ACK);
        end else begin
            n_pass++;
        end
        cyc;
        n_chk++;
        if (BUSY !== 1'b0 || ACK !== 1'b1) begin
            $display("FAIL %s_apply: BUSY=%b ACK=%b, want 0 1", tag, BUSY, ACK);
        end else begin
            n_pass++;
        end
    endtask

    task automatic test_reset;
        RST  = 1'b1;
        EN   = 1'b1;
        LOAD = 1'b1;
        DIV  = W'(5);
        cyc;
        cyc;
        n_chk++;
        if ({O, ACTIVE, BUSY, ACK} !== 4'b0000) begin
            $display("FAIL reset: O/ACTIVE/BUSY/ACK=%b, want 0000",
                     {O, ACTIVE, BUSY, ACK});
        end else begin
            n_pass++;
        end
        RST  = 1'b0;
        EN   = 1'b0;
        LOAD = 1'b0;
        cyc;
        n_chk++;
        if ({O, ACTIVE, BUSY, ACK} !== 4'b0000) begin
            $display("FAIL reset_idle: O/ACTIVE/BUSY/ACK=%b, want 0000",
                     {O, ACTIVE, BUSY, ACK});
        end else begin
            n_pass++;
        end
    endtask

    task automatic test_ratio(input int code, input int cycles);
        int n, h;
        logic exp_o;
        load_idle(code, "ratio");
        n  = ratio(code);
        h  = hi_len(n);
        EN = 1'b1;
        for (int i = 0; i < cycles; i++) begin
            cyc;
            exp_o = ((i % n) < h);
            n_chk++;
            if (O !== exp_o || ACTIVE !== 1'b1) begin
                $display("FAIL ratio_div%0d cyc%0d: O=%b ACTIVE=%b, want O=%b ACTIVE=1",
                         code, i, O, ACTIVE, exp_o);
            end else begin
                n_pass++;
            end
        end
        go_idle("ratio");
    endtask

    task automatic test_drain;
        bit en_t [15] = '{1,1,0,0,0,0,1,1,0,1,1,1,1,0,0};
        bit o_t  [15] = '{1,1,0,0,0,0,1,1,0,0,1,1,0,0,0};
        bit a_t  [15] = '{1,1,1,1,0,0,1,1,1,1,1,1,1,1,0};
        load_idle(3, "drain");
        for (int s = 0; s < 15; s++) begin
            EN = en_t[s];
            cyc;
            n_chk++;
            if (O !== o_t[s] || ACTIVE !== a_t[s]) begin
                $display("FAIL drain step%0d: O=%b ACTIVE=%b, want O=%b ACTIVE=%b",
                         s, O, ACTIVE, o_t[s], a_t[s]);
            end else begin
                n_pass++;
            end
        end
        go_idle("drain");
    endtask

    task automatic test_switch;
        logic exp_o;
        load_idle(3, "switch");
        EN = 1'b1;
        cyc;
        cyc;
        LOAD = 1'b1;
        DIV  = W'(7);
        cyc;
        LOAD = 1'b0;
        n_chk++;
        if (BUSY !== 1'b1 || ACK !== 1'b0 || O !== 1'b0) begin
            $display("FAIL switch_load: BUSY=%b ACK=%b O=%b, want 1 0 0", BUSY, ACK, O);
        end else begin
            n_pass++;
        end
        if (SAFE) begin
            cyc;
            n_chk++;
            if (BUSY !== 1'b1 || ACK !== 1'b0 || O !== 1'b0) begin
                $display("FAIL switch_hold: BUSY=%b ACK=%b O=%b, want 1 0 0", BUSY, ACK, O);
            end else begin
                n_pass++;
            end
        end
        cyc;
        n_chk++;
        if (BUSY !== 1'b0 || ACK !== 1'b1 || O !== 1'b1) begin
            $display("FAIL switch_ack: BUSY=%b ACK=%b O=%b, want 0 1 1", BUSY, ACK, O);
        end else begin
            n_pass++;
        end
        for (int i = 1; i <= 8; i++) begin
            cyc;
            exp_o = ((i % 8) < 4);
            n_chk++;
            if (O !== exp_o || ACK !== 1'b0) begin
                $display("FAIL switch_n8 cyc%0d: O=%b ACK=%b, want O=%b ACK=0",
                         i, O, ACK, exp_o);
            end else begin
                n_pass++;
            end
        end
        go_idle("switch");
    endtask

    task automatic test_back_to_back;
        int  k;
        bit  seen;
        logic exp_o;
        load_idle(3, "b2b");
        EN = 1'b1;
        cyc;
        cyc;
        LOAD = 1'b1;
        DIV  = W'(2);
        cyc;
        DIV = W'(5);
        cyc;
        LOAD = 1'b0;
        n_chk++;
        if (BUSY !== 1'b1 || ACK !== 1'b0) begin
            $display("FAIL b2b_loads: BUSY=%b ACK=%b, want 1 0", BUSY, ACK);
        end else begin
            n_pass++;
        end
        seen = 1'b0;
        k    = 0;
        while (!seen && k < 8) begin
            cyc;
            k++;
            if (ACK === 1'b1) seen = 1'b1;
        end
        n_chk++;
        if (!seen || O !== 1'b1 || BUSY !== 1'b0) begin
            $display("FAIL b2b_ack: seen=%0d O=%b BUSY=%b after %0d cyc, want 1 1 0",
                     seen, O, BUSY, k);
        end else begin
            n_pass++;
        end
        for (int i = 1; i < 12; i++) begin
            cyc;
            exp_o = ((i % 6) < 3);
            n_chk++;
            if (O !== exp_o || ACK !== 1'b0) begin
                $display("FAIL b2b_n6 cyc%0d: O=%b ACK=%b, want O=%b ACK=0",
                         i, O, ACK, exp_o);
            end else begin
                n_pass++;
            end
        end
        go_idle("b2b");
    endtask

    task automatic test_rst_mid;
        logic exp_o;
        load_idle(7, "rstmid");
        EN = 1'b1;
        cyc;
        cyc;
        LOAD = 1'b1;
        DIV  = W'(3);
        cyc;
        LOAD = 1'b0;
        n_chk++;
        if (O !== 1'b1 || BUSY !== 1'b1) begin
            $display("FAIL rstmid_pre: O=%b BUSY=%b, want 1 1", O, BUSY);
        end else begin
            n_pass++;
        end
        RST = 1'b1;
        cyc;
        n_chk++;
        if ({O, ACTIVE, BUSY, ACK} !== 4'b0000) begin
            $display("FAIL rstmid_rst: O/ACTIVE/BUSY/ACK=%b, want 0000",
                     {O, ACTIVE, BUSY, ACK});
        end else begin
            n_pass++;
        end
        RST = 1'b0;
        for (int i = 0; i < 6; i++) begin
            cyc;
            exp_o = ((i % 2) == 0);
            n_chk++;
            if (O !== exp_o) begin
                $display("FAIL rstmid_init cyc%0d: O=%b, want %b", i, O, exp_o);
            end else begin
                n_pass++;
            end
        end
        go_idle("rstmid");
    endtask

    task automatic model_reset;
        m_code = 0;
        m_pend = 0;
        m_pos  = 0;
        m_busy = 1'b0;
        m_on   = 1'b0;
        m_stop = 1'b0;
        m_ack  = 1'b0;
    endtask

    task automatic model_step(input bit rst, input bit en, input bit ld, input int dv);
        int n;
        bit at_end, apply, was_on;
        if (rst) begin
            model_reset;
            return;
        end
        n      = ratio(m_code);
        at_end = m_on && (m_pos == n - 1);
        apply  = m_busy && !ld && (!m_on || !SAFE || at_end);
        was_on = m_on;
        m_ack  = 1'b0;
        if (!m_on) begin
            if (en) begin
                m_on   = 1'b1;
                m_stop = 1'b0;
                m_pos  = 0;
            end
        end else if (m_stop && !en && at_end) begin
            m_on  = 1'b0;
            m_pos = 0;
        end else begin
            m_pos  = at_end ? 0 : m_pos + 1;
            m_stop = !en;
        end
        if (apply) begin
            m_code = m_pend;
            m_busy = 1'b0;
            m_ack  = 1'b1;
            if (was_on) m_pos = 0;
        end
        if (ld) begin
            m_pend = dv;
            m_busy = 1'b1;
        end
    endtask

    task automatic test_random;
        logic exp_o;
        RST  = 1'b1;
        EN   = 1'b0;
        LOAD = 1'b0;
        cyc;
        RST = 1'b0;
        model_reset;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 15) == 0) EN = ~EN;
            LOAD = ($urandom_range(0, 9) == 0);
            DIV  = W'($urandom_range(0, 15));
            RST  = ($urandom_range(0, 499) == 0);
            model_step(RST, EN, LOAD, int'(DIV));
            cyc;
            exp_o = m_on && (m_pos < hi_len(ratio(m_code)));
            n_chk++;
            if ({O, ACTIVE, BUSY, ACK} !== {exp_o, m_on, m_busy, m_ack}) begin
                $display("FAIL random cyc%0d: O/ACTIVE/BUSY/ACK=%b, want %b",
                         c, {O, ACTIVE, BUSY, ACK}, {exp_o, m_on, m_busy, m_ack});
            end else begin
                n_pass++;
            end
        end
        RST  = 1'b0;
        LOAD = 1'b0;
        go_idle("random");
    endtask

    initial begin
        test_reset;
        test_ratio(3, 12);
        test_ratio(4, 15);
        test_ratio(0, 8);
        test_ratio(1, 8);
        test_ratio(15, 32);
        test_drain;
        test_switch;
        test_back_to_back;
        test_rst_mid;
        test_random;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/fclk_div.md
FCLK_DIV -- requirements
Module: fclk_div

Interface
REQ-001 SHALL declare parameter DIV_WIDTH, default 4, meaning the width of DIV and of the internal period counter.
REQ-002 SHALL declare parameter INIT_DIV, default 0, meaning the divide code loaded at reset.
REQ-003 SHALL have port CLK  input  1  source clock; all logic on its rising edge.
REQ-004 SHALL have port RST  input  1  synchronous, active-high reset.
REQ-005 SHALL have port EN  input  1  run request; 1 = generate the divided clock, 0 = stop cleanly.
REQ-006 SHALL have port DIV  input  DIV_WIDTH  divide code; ratio N = max(DIV+1, 2).
REQ-007 SHALL have port LOAD  input  1  single-cycle strobe that captures DIV as the pending ratio.
REQ-008 SHALL have port O  output  1  registered divided clock; feeds FCLK_BUF input I directly.
REQ-009 SHALL have port ACTIVE  output  1  high while the state is RUN or DRAIN.
REQ-010 SHALL have port BUSY  output  1  high while a loaded ratio is pending and not yet applied.
REQ-011 SHALL have port ACK  output  1  one-cycle pulse in the cycle a pending ratio becomes current.

Function
REQ-012 SHALL implement states IDLE, RUN and DRAIN.
REQ-013 SHALL take transitions IDLE->RUN when EN=1; RUN->DRAIN when EN=0; DRAIN->IDLE at end of period; DRAIN->RUN when EN=1 returns before end of period, with no glitch and no counter reset.
REQ-014 SHALL, in RUN and DRAIN, use counter cnt counting 0..N-1 and wrapping to 0; "end of period" means cnt=N-1.
REQ-015 SHALL register O <= (cnt_next < ceil(N/2)): high phase ceil(N/2) cycles, low phase floor(N/2) cycles; for odd N the extra cycle is high.
REQ-016 SHALL raise O on the first CLK edge after entering RUN from IDLE, i.e. one cycle of latency from EN sampled high.
REQ-017 SHALL hold O at 0 and cnt at 0 in IDLE; SHALL never truncate a high or low phase when stopping.
REQ-018 SHALL, on LOAD=1, capture DIV into pending and set BUSY=1; a LOAD while BUSY=1 overwrites pending, and only the last value applies.
REQ-019 SHALL apply the pending ratio per the Configuration requirements, pulsing ACK and clearing BUSY in the same cycle.
REQ-020 SHALL apply a LOAD in IDLE on the next cycle regardless of the macro.
REQ-021 SHALL treat DIV=0 and DIV=1 as N=2, and SHALL treat the all-ones code as N=2^DIV_WIDTH; no overflow is permitted in the ceil/floor arithmetic (use DIV_WIDTH+1 bits).
REQ-022 SHALL let RST take priority when RST and LOAD, or RST and EN, are asserted together.

Reset
REQ-023 SHALL, on RST=1, set state=IDLE, cnt=0, O=0, ACTIVE=0, BUSY=0, ACK=0, current ratio=INIT_DIV, pending cleared.
REQ-024 SHALL, on RST asserted mid-period, force O low on the same edge; this is the only permitted phase truncation.

Configuration
REQ-025 SHALL, with macro FCLK_DIV_SAFE_SWITCH_EN defined, apply the pending ratio only at end of period (cnt=N-1), so that every output period is complete at either the old or the new N.
REQ-026 SHALL, without FCLK_DIV_SAFE_SWITCH_EN, apply the pending ratio on the cycle after LOAD, reset cnt to 0 and drive O high on that edge; this permits one shortened period.

Verification
REQ-027 SHALL cover: RST, DIV=3 (N=4), EN=1 -> O pattern 1100 repeating, first O=1 one cycle after EN, ACTIVE=1.
REQ-028 SHALL cover: DIV=4 (N=5) -> high 3 cycles, low 2 cycles; DIV=0 -> O toggles every cycle (N=2).
REQ-029 SHALL cover: EN dropped at cnt=1 with N=4 -> O completes 1100, then stays 0; ACTIVE falls at cnt wrap; EN re-raised during DRAIN -> output continues seamlessly.
REQ-030 SHALL cover, with FCLK_DIV_SAFE_SWITCH_EN: N=4 running, LOAD DIV=7 at cnt=1 -> BUSY=1 until cnt=3, ACK pulse, then 11110000 with no short period; without the macro -> ACK on the next cycle and O restarts high.
REQ-031 SHALL cover: two LOADs (DIV=2, then DIV=5) within one period -> a single ACK and N=6 applied.
REQ-032 SHALL cover: RST pulsed mid-high-phase -> O=0 on the same edge, BUSY=0, and the ratio returns to INIT_DIV.
